load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Executes LOAD_STORE instructions (LDV/SV) issued by the instruction sequencer.
- Moves one D-element vector of 8-bit fixed-point values between the byte-wide DDR port and the vector register file (VRF), one element per DDR transaction.
- Sits between the sequencer/decoder (upstream) and the DDR model plus VRF (downstream).
- Accepts one instruction at a time and signals completion with a single-cycle done pulse.

Parameters:
- D, 4, vector length in elements.
- ELEM_W, 8, element width in bits (equals FixedPointPrecision).
- DDR_ADDR_W, 16, DDR address width.
- V_ADDR_W, 2, VRF index width (log2 of NumVectorRegisters).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  instruction valid; accepted only when ready_o=1
- ready_o  out  1  unit idle, can accept an instruction
- op_i  in  2  load_store_operation_t: 0=LDV, 1=SV, others invalid
- v_addr_i  in  V_ADDR_W  VRF index
- ddr_base_i  in  DDR_ADDR_W  address of element 0
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle timeout pulse, coincident with done_o
- ddr_req_o  out  1  DDR request
- ddr_we_o  out  1  1=write, 0=read
- ddr_addr_o  out  DDR_ADDR_W  DDR address
- ddr_wdata_o  out  ELEM_W  write data
- ddr_gnt_i  in  1  request accepted this cycle
- ddr_rvalid_i  in  1  read data valid
- ddr_rdata_i  in  ELEM_W  read data
- vrf_raddr_o  out  V_ADDR_W  VRF read index
- vrf_rdata_i  in  D*ELEM_W  VRF read data, combinational
- vrf_we_o  out  1  VRF write enable
- vrf_waddr_o  out  V_ADDR_W  VRF write index
- vrf_wdata_o  out  D*ELEM_W  VRF write data

Behaviour:
- Single clock clk_i; rst_ni is asynchronous, active-low.
- Reset forces state IDLE and counters/buffer to 0. Outputs at reset: ready_o=1, all other outputs 0.
- Element i maps to DDR address ddr_base+i (mod 2^DDR_ADDR_W; 0xFFFF+1 wraps to 0x0000) and to VRF bits [i*ELEM_W +: ELEM_W].
- FSM states: IDLE, LD_REQ, LD_WAIT, LD_WB, ST_REQ, FINISH.
- IDLE:
  - ready_o=1; vrf_raddr_o=v_addr_i.
  - On start_i: latch op, v_addr, base; clear idx.
  - LDV -> LD_REQ.
  - SV: latch vrf_rdata_i into buffer in the same cycle -> ST_REQ.
  - Invalid op -> FINISH; no DDR or VRF activity.
- LD_REQ: ddr_req_o=1, ddr_we_o=0, ddr_addr_o=base+idx. On ddr_gnt_i -> LD_WAIT.
- LD_WAIT:
  - req deasserted; only one outstanding transaction.
  - On ddr_rvalid_i: buffer[idx]=ddr_rdata_i.
  - If idx==D-1 -> LD_WB; else idx++ -> LD_REQ.
  - An rvalid arriving in the same cycle as gnt, or outside LD_WAIT, is ignored.
- LD_WB: vrf_we_o=1 for exactly one cycle, vrf_waddr_o=latched v_addr, vrf_wdata_o=buffer -> FINISH.
- ST_REQ:
  - ddr_req_o=1, ddr_we_o=1, addr=base+idx, wdata=buffer[idx].
  - On gnt: if idx==D-1 -> FINISH; else idx++.
  - With continuous gnt, back-to-back writes take 1 cycle each.
- FINISH: done_o=1 for one cycle -> IDLE. ready_o returns the cycle after done_o.
- Request stability: ddr_addr_o, ddr_we_o and ddr_wdata_o hold steady while ddr_req_o=1 and gnt is low.
- start_i while busy is ignored.
- Reset mid-operation aborts: no VRF write, no done_o, DDR request dropped immediately.
- Minimum latency from accept to done_o, with gnt and rvalid each one cycle after request:
  - LDV: 1 + 2D + 1 cycles.
  - SV: D + 1 cycles.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to LD_REQ, LD_WAIT and ST_REQ.
  - It increments each cycle spent waiting for gnt or rvalid.
  - When it reaches TIMEOUT_CYCLES, the operation aborts: no VRF write, go to FINISH, err_o=1 together with done_o.
- Undefined: no counter; err_o tied 0; the unit waits indefinitely.

Test Plan:
- LDV, v=2, base=0x0100, DDR returns 0x11,0x22,0x33,0x44 -> one vrf_we_o pulse, waddr=2, wdata=0x44332211, done_o one cycle after the write.
- SV, v=1, VRF[1]=0xA0B0C0D0, gnt always high -> writes 0xD0@0x0200, 0xC0@0x0201, 0xB0@0x0202, 0xA0@0x0203 in consecutive cycles; done_o next cycle.
- LDV, base=0xFFFE -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- gnt stalled 5 cycles on element 1 of SV -> addr/wdata stable throughout; start_i pulsed mid-op ignored; 4 writes total.
- rst_ni low during LD_WAIT of element 2 -> no vrf_we_o, no done_o; ready_o=1 immediately; a following LDV completes correctly.
- With LSU_TIMEOUT_EN: no gnt for 64 cycles -> done_o=1 and err_o=1, vrf_we_o never asserted. Invalid op=3 -> done_o 1 cycle after accept, no DDR request.

Source files
------------

// File: rtl/load_store_unit.sv
// Vector load/store unit: moves one D-element vector between a byte-wide DDR port and the VRF.
// Optional watchdog abort on stalled DDR handshakes is enabled with `define LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned D              = 4,
  parameter int unsigned ELEM_W         = 8,
  parameter int unsigned DDR_ADDR_W     = 16,
  parameter int unsigned V_ADDR_W       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  logic [V_ADDR_W-1:0]   v_addr_i,
  input  logic [DDR_ADDR_W-1:0] ddr_base_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  ddr_req_o,
  output logic                  ddr_we_o,
  output logic [DDR_ADDR_W-1:0] ddr_addr_o,
  output logic [ELEM_W-1:0]     ddr_wdata_o,
  input  logic                  ddr_gnt_i,
  input  logic                  ddr_rvalid_i,
  input  logic [ELEM_W-1:0]     ddr_rdata_i,
  output logic [V_ADDR_W-1:0]   vrf_raddr_o,
  input  logic [D*ELEM_W-1:0]   vrf_rdata_i,
  output logic                  vrf_we_o,
  output logic [V_ADDR_W-1:0]   vrf_waddr_o,
  output logic [D*ELEM_W-1:0]   vrf_wdata_o
);

  localparam int unsigned IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  if (D < 2 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("load_store_unit: D must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    OP_LDV = 2'd0,
    OP_SV  = 2'd1
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_REQ,
    S_FINISH
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [V_ADDR_W-1:0]     r_vaddr;
  logic [DDR_ADDR_W-1:0]   r_base;
  logic [IDX_W-1:0]        r_idx;
  logic [D*ELEM_W-1:0]     r_buf;

  logic                    w_accept;
  logic                    w_buf_from_vrf;
  logic                    w_buf_elem_wr;
  logic                    w_idx_inc;
  logic                    w_wdog_clr;
  logic                    w_wdog_inc;
  logic                    w_err_set;
  logic                    w_timeout;
  logic [DDR_ADDR_W-1:0]   w_addr;

  assign w_addr = r_base + DDR_ADDR_W'(r_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    ready_o        = 1'b0;
    done_o         = 1'b0;
    ddr_req_o      = 1'b0;
    ddr_we_o       = 1'b0;
    ddr_addr_o     = '0;
    ddr_wdata_o    = '0;
    vrf_raddr_o    = '0;
    vrf_we_o       = 1'b0;
    vrf_waddr_o    = '0;
    vrf_wdata_o    = '0;
    w_accept       = 1'b0;
    w_buf_from_vrf = 1'b0;
    w_buf_elem_wr  = 1'b0;
    w_idx_inc      = 1'b0;
    w_wdog_clr     = 1'b0;
    w_wdog_inc     = 1'b0;
    w_err_set      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        ready_o     = 1'b1;
        vrf_raddr_o = v_addr_i;
        if (start_i) begin
          w_accept = 1'b1;
          case (op_i)
            OP_LDV:  w_state_nxt = S_LD_REQ;
            OP_SV: begin
              w_buf_from_vrf = 1'b1;
              w_state_nxt    = S_ST_REQ;
            end
            default: w_state_nxt = S_FINISH;
          endcase
        end
      end

      S_LD_REQ: begin
        ddr_req_o  = 1'b1;
        ddr_addr_o = w_addr;
        if (ddr_gnt_i) begin
          w_wdog_clr  = 1'b1;
          w_state_nxt = S_LD_WAIT;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_wdog_inc = 1'b1;
        end
      end

      S_LD_WAIT: begin
        if (ddr_rvalid_i) begin
          w_buf_elem_wr = 1'b1;
          w_wdog_clr    = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_LD_WB;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = S_LD_REQ;
          end
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_wdog_inc = 1'b1;
        end
      end

      S_LD_WB: begin
        vrf_we_o    = 1'b1;
        vrf_waddr_o = r_vaddr;
        vrf_wdata_o = r_buf;
        w_state_nxt = S_FINISH;
      end

      S_ST_REQ: begin
        ddr_req_o   = 1'b1;
        ddr_we_o    = 1'b1;
        ddr_addr_o  = w_addr;
        ddr_wdata_o = r_buf[r_idx*ELEM_W +: ELEM_W];
        if (ddr_gnt_i) begin
          w_wdog_clr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_idx_inc = 1'b1;
          end
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_wdog_inc = 1'b1;
        end
      end

      S_FINISH: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vaddr <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      if (w_accept) begin
        r_vaddr <= v_addr_i;
        r_base  <= ddr_base_i;
        r_idx   <= '0;
      end
      if (w_buf_from_vrf) begin
        r_buf <= vrf_rdata_i;
      end
      if (w_buf_elem_wr) begin
        r_buf[r_idx*ELEM_W +: ELEM_W] <= ddr_rdata_i;
      end
      if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  // Counter holds the number of wait cycles already spent; the final one aborts.
  assign w_timeout = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign err_o     = (r_state == S_FINISH) && r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept || w_wdog_clr) begin
        r_wdog <= '0;
      end else if (w_wdog_inc) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule
